uart_tx_arbiter: RTL



---
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Round-robin, per-byte arbiter with per-requester lock in front
//             of the shared UART transmitter byte interface.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     stb_i,
  input  logic [8*NUM_REQ-1:0]   data_i,
  input  logic [NUM_REQ-1:0]     lock_i,
  output logic [NUM_REQ-1:0]     ack_o,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   busy_o,
  output logic                   stb_o,
  output logic [7:0]             data_o,
  input  logic                   ack_i
);

  localparam int                 IW       = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_LOCK = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        last_q, last_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 stb_q, stb_d;
  logic [7:0]           data_q, data_d;

  logic [NUM_REQ-1:0]   elig;
  logic                 pick_valid;
  logic [IW-1:0]        pick_idx;
  logic [IW-1:0]        cand;
  logic                 issue;
  logic [IW-1:0]        issue_idx;

  // A request seen in its own ack cycle is stale; masking it prevents a resend.
  assign elig = stb_i & ~ack_q;

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(last_q) + i) % NUM_REQ);
      if (!pick_valid && elig[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    ack_d     = '0;
    stb_d     = 1'b0;
    data_d    = data_q;
    issue     = 1'b0;
    issue_idx = owner_q;

    case (state_q)
      ARB_IDLE: begin
        grant_d = '0;
        if (pick_valid) begin
          issue     = 1'b1;
          issue_idx = pick_idx;
        end
      end
      ARB_WAIT: begin
        if (ack_i) begin
          ack_d[owner_q] = 1'b1;
          last_d         = owner_q;
          if (lock_i[owner_q]) begin
            state_d = ARB_LOCK;
          end else begin
            state_d = ARB_IDLE;
            grant_d = '0;
          end
        end
      end
      ARB_LOCK: begin
        // Owner's pending byte wins over its lock release in the same cycle.
        if (elig[owner_q]) begin
          issue     = 1'b1;
          issue_idx = owner_q;
        end else if (!lock_i[owner_q]) begin
          state_d = ARB_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase

    if (issue) begin
      data_d  = data_i[8*issue_idx +: 8];
      stb_d   = 1'b1;
      grant_d = ONE_HOT0 << issue_idx;
      owner_d = issue_idx;
      state_d = ARB_WAIT;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      last_q  <= IW'(NUM_REQ - 1);
      owner_q <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      stb_q   <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      stb_q   <= stb_d;
      data_q  <= data_d;
    end
  end

  assign ack_o   = ack_q;
  assign grant_o = grant_q;
  assign busy_o  = (state_q != ARB_IDLE);
  assign stb_o   = stb_q;
  assign data_o  = data_q;

endmodule

`default_nettype wire
